// File: rtl/rom_line_cache.sv
// Direct-mapped, one-word-per-line read cache between the core ROM port and the ddram
// read port. Both sides use toggle handshakes: a request is pending while req != ack.
module rom_line_cache #(
  parameter int ADDR_W     = 20,
  parameter int LINES_LOG2 = 6
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_req,
  output logic              cpu_ack,
  output logic [63:0]       cpu_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [63:0]       mem_din,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int LINES = 1 << LINES_LOG2;
  localparam int TAG_W = ADDR_W - LINES_LOG2;

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_FILL   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]     addr_q;
  logic [LINES_LOG2-1:0] idx_q;
  logic [LINES_LOG2-1:0] cpu_idx;
  logic [LINES_LOG2-1:0] sweep_cnt_q;
  logic [TAG_W-1:0]      tag_q;
  logic [TAG_W-1:0]      tag_rd;
  logic [63:0]           data_rd;
  logic [LINES-1:0]      valid_q;
  logic                  sweep_done_q;
  logic                  sweep_last;
  logic                  flush_pend_q;
  logic                  flush_any;
  logic                  req_pending;
  logic                  fill_done;
  logic                  hit;

  logic [TAG_W-1:0] tag_ram  [LINES];
  logic [63:0]      data_ram [LINES];

  assign idx_q       = addr_q[LINES_LOG2-1:0];
  assign tag_q       = addr_q[ADDR_W-1:LINES_LOG2];
  assign cpu_idx     = cpu_addr[LINES_LOG2-1:0];
  assign req_pending = cpu_req != cpu_ack;
  assign fill_done   = mem_ack == mem_req;
  assign flush_any   = flush | flush_pend_q;
  assign sweep_last  = sweep_cnt_q == LINES_LOG2'(LINES - 1);
  assign hit         = valid_q[idx_q] && (tag_rd == tag_q);
  assign busy        = state_q != ST_IDLE;
  assign state_dbg   = state_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_FLUSH;
    else          state_q <= state_d;
  end

  // The sweep may end on the cycle that clears the last line, so FLUSH lasts exactly LINES cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FLUSH:  if ((sweep_done_q || sweep_last) && !flush) state_d = ST_IDLE;
      ST_IDLE: begin
        if (flush)            state_d = ST_FLUSH;
        else if (req_pending) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (!hit)           state_d = ST_FILL;
        else if (flush_any) state_d = ST_FLUSH;
        else                state_d = ST_IDLE;
      end
      ST_FILL:   if (fill_done) state_d = flush_any ? ST_FLUSH : ST_IDLE;
      default:   state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sweep_cnt_q  <= '0;
      sweep_done_q <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      if (state_q != ST_FLUSH && state_d == ST_FLUSH) begin
        sweep_cnt_q  <= '0;
        sweep_done_q <= 1'b0;
      end else if (state_q == ST_FLUSH && !sweep_done_q) begin
        sweep_cnt_q <= sweep_cnt_q + LINES_LOG2'(1);
        if (sweep_last) sweep_done_q <= 1'b1;
      end
      // A flush seen while a request is in flight is remembered until FLUSH is entered.
      if (state_q == ST_FLUSH)
        flush_pend_q <= 1'b0;
      else if (flush && (state_q == ST_LOOKUP || state_q == ST_FILL))
        flush_pend_q <= 1'b1;
    end
  end

  // Valid bits need no reset: the FSM always sweeps them after reset.
  always_ff @(posedge clk_sys) begin
    if (state_q == ST_FLUSH && !sweep_done_q)
      valid_q[sweep_cnt_q] <= 1'b0;
    else if (state_q == ST_FILL && fill_done && !flush_any)
      valid_q[idx_q] <= 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (state_q == ST_FILL && fill_done) begin
      tag_ram[idx_q]  <= tag_q;
      data_ram[idx_q] <= mem_din;
    end
    if (state_q == ST_IDLE) begin
      tag_rd  <= tag_ram[cpu_idx];
      data_rd <= data_ram[cpu_idx];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      cpu_ack  <= 1'b0;
      cpu_dout <= '0;
      mem_addr <= '0;
      mem_req  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:   if (!flush && req_pending) addr_q <= cpu_addr;
        ST_LOOKUP: begin
          if (hit) begin
            cpu_dout <= data_rd;
            cpu_ack  <= cpu_req;
          end else begin
            mem_addr <= addr_q;
            mem_req  <= ~mem_req;
          end
        end
        ST_FILL: begin
          if (fill_done) begin
            cpu_dout <= mem_din;
            cpu_ack  <= cpu_req;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_line_cache.sv
// Bench for rom_line_cache: directed vector table, hand-written flush/reset sequences
// and randomized reads checked against a line-state model of a direct-mapped cache.
module tb_rom_line_cache;

  localparam int LINES = 64;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        flush    = 1'b0;
  logic [19:0] cpu_addr = '0;
  logic        cpu_req  = 1'b0;
  logic        cpu_ack;
  logic [63:0] cpu_dout;
  logic [19:0] mem_addr;
  logic        mem_req;
  logic        mem_ack  = 1'b0;
  logic [63:0] mem_din  = '0;
  logic        busy;
  logic [1:0]  state_dbg;

  rom_line_cache #(.ADDR_W(20), .LINES_LOG2(6)) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .flush     (flush),
    .cpu_addr  (cpu_addr),
    .cpu_req   (cpu_req),
    .cpu_ack   (cpu_ack),
    .cpu_dout  (cpu_dout),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_din   (mem_din),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk_sys = ~clk_sys;

  int          checks      = 0;
  int          passes      = 0;
  int          mem_lat     = 1;
  logic        mem_stall   = 1'b0;
  int          mem_fetches = 0;
  int          fetch_base  = 0;
  logic [19:0] mem_last_addr = '0;
  logic [63:0] exp_q[$];

  logic        m_valid [LINES];
  logic [13:0] m_tag   [LINES];

  typedef struct {
    logic [19:0] addr;
    logic        exp_miss;
    logic [63:0] exp_data;
    string       name;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [63:0] mem_word(input logic [19:0] a);
    if (a == 20'h00010) return 64'h0123456789ABCDEF;
    return {12'h5A5, a, a ^ 20'hC3A5F, 12'h0F0};
  endfunction

  function automatic logic model_hit(input logic [19:0] a);
    return m_valid[a[5:0]] && (m_tag[a[5:0]] == a[19:6]);
  endfunction

  task automatic model_fill(input logic [19:0] a);
    m_valid[a[5:0]] = 1'b1;
    m_tag[a[5:0]]   = a[19:6];
  endtask

  task automatic model_flush();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ddram responder: acks mem_lat cycles after a toggle unless stalled; cleared by reset.
  initial begin : ddram_model
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (!reset_n) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_req != mem_ack) begin
        if (!mem_stall && wait_cnt >= mem_lat) begin
          mem_din       = mem_word(mem_addr);
          mem_last_addr = mem_addr;
          mem_ack       = mem_req;
          mem_fetches++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    if (busy) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic start_read(input logic [19:0] a, input logic [63:0] d);
    cpu_addr = a;
    exp_q.push_back(d);
    fetch_base = mem_fetches;
    cpu_req = ~cpu_req;
  endtask

  task automatic finish_read(input string name, input logic exp_miss);
    int          edges;
    logic [63:0] exp;
    edges = 0;
    while (cpu_ack !== cpu_req && edges < 500) begin
      @(posedge clk_sys);
      #1;
      edges++;
    end
    chk({name, "_ack"}, 64'(cpu_ack), 64'(cpu_req));
    exp = exp_q.pop_front();
    chk({name, "_data"}, cpu_dout, exp);
    chk({name, "_miss"}, 64'(mem_fetches - fetch_base), 64'(exp_miss));
    if (exp_miss) chk({name, "_maddr"}, 64'(mem_last_addr), 64'(cpu_addr));
    else          chk({name, "_lat"}, 64'(edges), 64'd2);
  endtask

  task automatic read_exp(input logic [19:0] a, input logic [63:0] d,
                          input logic exp_miss, input string name);
    int n;
    wait_idle(n);
    start_read(a, d);
    finish_read(name, exp_miss);
    model_fill(a);
  endtask

  task automatic read(input logic [19:0] a, input string name);
    read_exp(a, mem_word(a), !model_hit(a), name);
  endtask

  task automatic wait_fill();
    int k;
    k = 0;
    while (mem_req === mem_ack && k < 50) begin
      @(posedge clk_sys);
      #1;
      k++;
    end
    chk("fill_entered", 64'(mem_req != mem_ack), 64'd1);
  endtask

  initial begin
    int          n;
    logic [19:0] a;
    logic [13:0] tags [4];
    model_flush();

    vecs[0] = '{20'h00010, 1'b1, 64'h0123456789ABCDEF, "t1_miss"};
    vecs[1] = '{20'h00010, 1'b0, 64'h0123456789ABCDEF, "t2_hit"};
    vecs[2] = '{20'h00050, 1'b1, mem_word(20'h00050), "t3_conflict"};
    vecs[3] = '{20'h00010, 1'b1, 64'h0123456789ABCDEF, "t3_evicted"};
    vecs[4] = '{20'h00050, 1'b1, mem_word(20'h00050), "t3_evict_back"};
    vecs[5] = '{20'hFFFFF, 1'b1, mem_word(20'hFFFFF), "wrap_miss"};
    vecs[6] = '{20'hFFFFF, 1'b0, mem_word(20'hFFFFF), "wrap_hit"};
    vecs[7] = '{20'h0003F, 1'b1, mem_word(20'h0003F), "idx63_alias"};
    vecs[8] = '{20'hFFFFF, 1'b1, mem_word(20'hFFFFF), "wrap_refill"};

    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_cpu_dout", cpu_dout, 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    reset_n = 1'b1;
    wait_idle(n);
    chk("rst_sweep_len", 64'(n >= 64 && n <= 70), 64'd1);

    for (int i = 0; i < 9; i++)
      read_exp(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_miss, vecs[i].name);

    // Fill every line, then a one-cycle flush pulse must sweep them all.
    mem_lat = 0;
    for (int i = 0; i < LINES; i++) read(20'(i), "t4_fill");
    read_exp(20'h00005, mem_word(20'h00005), 1'b0, "t4_prehit");
    flush = 1'b1;
    @(posedge clk_sys);
    #1;
    flush = 1'b0;
    wait_idle(n);
    chk("t4_flush_busy", 64'(n >= 64 && n <= 70), 64'd1);
    model_flush();
    read_exp(20'h00005, mem_word(20'h00005), 1'b1, "t4_after_flush");

    // Flush during FILL: data still returned, line left invalid, sweep follows.
    mem_lat = 2;
    a = 20'h0ABCD;
    wait_idle(n);
    mem_stall = 1'b1;
    start_read(a, mem_word(a));
    wait_fill();
    flush = 1'b1;
    @(posedge clk_sys);
    #1;
    flush = 1'b0;
    mem_stall = 1'b0;
    finish_read("t5_flush_fill", 1'b1);
    chk("t5_flush_follows", 64'(busy), 64'd1);
    model_flush();
    read_exp(a, mem_word(a), 1'b1, "t5_reread");

    // A request raised during a flush sweep is held and served afterwards.
    read(20'h00123, "t7_prefill");
    flush = 1'b1;
    @(posedge clk_sys);
    #1;
    flush = 1'b0;
    model_flush();
    start_read(20'h00123, mem_word(20'h00123));
    finish_read("t7_held_req", 1'b1);
    model_fill(20'h00123);

    // Reset mid-FILL abandons the transaction and re-sweeps the lines.
    for (int i = 0; i < 4; i++) read(20'h00100 + 20'(i), "t6_prefill");
    wait_idle(n);
    mem_stall = 1'b1;
    start_read(20'h12345, mem_word(20'h12345));
    wait_fill();
    reset_n = 1'b0;
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("t6_rst_cpu_ack", 64'(cpu_ack), 64'd0);
    chk("t6_rst_mem_req", 64'(mem_req), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    mem_stall = 1'b0;
    wait_idle(n);
    chk("t6_sweep_len", 64'(n >= 64 && n <= 70), 64'd1);
    model_flush();
    for (int i = 0; i < 4; i++)
      read_exp(20'h00100 + 20'(i), mem_word(20'h00100 + 20'(i)), 1'b1, "t6_old_miss");

    // Randomized reads over a small address pool so hits and evictions both occur.
    tags[0] = 14'h0000;
    tags[1] = 14'h0001;
    tags[2] = 14'h0002;
    tags[3] = 14'h3FFF;
    for (int i = 0; i < 120; i++) begin
      mem_lat = $urandom_range(0, 4);
      if ($urandom_range(0, 15) == 0) begin
        wait_idle(n);
        flush = 1'b1;
        @(posedge clk_sys);
        #1;
        flush = 1'b0;
        model_flush();
      end
      a = {tags[$urandom_range(0, 3)], 6'($urandom_range(0, 15))};
      if ($urandom_range(0, 7) == 0) a[5:0] = 6'h3F;
      read(a, "rand");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
